// File: rtl/fault_manager_pkg.sv
// Shared register map, field positions and helpers for the fault manager.
// Imported by the top level and the per-channel filter.
package fault_manager_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CTRL_W    = 2;
  localparam int unsigned TRIPCNT_W = 16;
  localparam int unsigned MAX_SRC   = 18;

  localparam logic [ADDR_W-1:0] REG_CTRL     = 8'h00;
  localparam logic [ADDR_W-1:0] REG_TIMEOUT  = 8'h04;
  localparam logic [ADDR_W-1:0] REG_KICK     = 8'h08;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 8'h0C;
  localparam logic [ADDR_W-1:0] REG_MASK     = 8'h10;
  localparam logic [ADDR_W-1:0] REG_FILTER   = 8'h14;
  localparam logic [ADDR_W-1:0] REG_FIRST    = 8'h18;
  localparam logic [ADDR_W-1:0] REG_RAW      = 8'h1C;
  localparam logic [ADDR_W-1:0] REG_TRIPCNT  = 8'h20;

  localparam int unsigned CTRL_WDT_EN    = 0;
  localparam int unsigned CTRL_FORCE_DIS = 1;

  localparam int unsigned FIRST_VALID_BIT = 7;
  localparam int unsigned FIRST_IDX_W     = 5;

  // Source indices above the channel range, as offsets from N_FAULT.
  localparam int unsigned SRC_ESTOP = 0;
  localparam int unsigned SRC_WDT   = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              full_sel;
  } wb_req_t;

  typedef struct packed {
    logic                   valid;
    logic [FIRST_IDX_W-1:0] idx;
  } first_t;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [FIRST_IDX_W-1:0] lowest_idx(input logic [MAX_SRC-1:0] v);
    logic [FIRST_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = FIRST_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fault_manager_filter.sv
// One fault channel: two-flop synchroniser, saturating high-time counter
// and a qualify strobe raised while the input has been high for thresh cycles.
module fault_filter
  import fault_manager_pkg::*;
#(
  parameter int unsigned FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_async,
  input  logic [FILT_W-1:0] thresh,
  output logic              level_o,
  output logic              qual_c
);

  logic              meta_q, meta_d;
  logic              sync_q, sync_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  // Counter clamps to the threshold so a lowered threshold still qualifies.
  always_comb begin
    meta_d = in_async;
    sync_d = meta_q;
    cnt_d  = '0;
    if (sync_q) begin
      cnt_d = (cnt_q >= thresh) ? thresh : cnt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = sync_q;
  assign qual_c  = sync_q && (cnt_q == thresh);

endmodule

// File: rtl/fault_manager.sv
// Fault protection block: filtered fault channels, e-stop, watchdog, sticky
// status with first-fault capture and a trip counter behind a Wishbone slave.
module fault_manager
  import fault_manager_pkg::*;
#(
  parameter int unsigned N_FAULT = 4,
  parameter int unsigned FILT_W  = 8,
  parameter int unsigned WDT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         wb_addr,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic               wb_we,
  input  logic [3:0]         wb_sel,
  input  logic               wb_stb,
  output logic               wb_ack,
  input  logic [N_FAULT-1:0] fault_in,
  input  logic               estop_n,
  output logic               pwm_disable,
  output logic               irq
);

  localparam int unsigned N_SRC     = N_FAULT + 2;
  localparam int unsigned IDX_ESTOP = N_FAULT + SRC_ESTOP;
  localparam int unsigned IDX_WDT   = N_FAULT + SRC_WDT;

  logic                 ack_q, ack_d;
  logic [DATA_W-1:0]    dat_q, dat_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [WDT_W-1:0]     timeout_q, timeout_d;
  logic [N_FAULT-1:0]   mask_q, mask_d;
  logic [FILT_W-1:0]    filter_q, filter_d;
  logic [N_SRC-1:0]     status_q, status_d;
  first_t               first_q, first_d;
  logic [WDT_W-1:0]     wdt_cnt_q, wdt_cnt_d;
  logic [TRIPCNT_W-1:0] tripcnt_q, tripcnt_d;
  logic                 trip_prev_q, trip_prev_d;
  logic                 estop_meta_q, estop_meta_d;
  logic                 estop_sync_q, estop_sync_d;

  wb_req_t              req;
  logic                 acc_c, wr_c, rd_c;
  logic                 ctrl_wr_c, timeout_wr_c, kick_wr_c, status_wr_c;
  logic                 mask_wr_c, filter_wr_c, tripcnt_wr_c;
  logic [N_FAULT-1:0]   chan_level, chan_qual;
  logic                 estop_live_c;
  logic                 wdt_en_c, wdt_load_c, wdt_set_c;
  logic [N_SRC-1:0]     set_c, trip_src_c, w1c_c, raw_c;
  logic                 latched_c, trip_c;
  logic [DATA_W-1:0]    first_word_c;

  for (genvar g = 0; g < N_FAULT; g++) begin : g_filt
    fault_filter #(
      .FILT_W(FILT_W)
    ) u_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_async(fault_in[g]),
      .thresh  (filter_q),
      .level_o (chan_level[g]),
      .qual_c  (chan_qual[g])
    );
  end

  // Bus request capture and per-register write strobes.
  always_comb begin
    req.addr     = wb_addr;
    req.data     = wb_dat_i;
    req.we       = wb_we;
    req.full_sel = (wb_sel == 4'hF);
    acc_c        = wb_stb && !ack_q;
    wr_c         = acc_c && req.we && req.full_sel;
    rd_c         = acc_c && !req.we;
    ctrl_wr_c    = wr_c && (req.addr == REG_CTRL);
    timeout_wr_c = wr_c && (req.addr == REG_TIMEOUT);
    kick_wr_c    = wr_c && (req.addr == REG_KICK);
    status_wr_c  = wr_c && (req.addr == REG_STATUS);
    mask_wr_c    = wr_c && (req.addr == REG_MASK);
    filter_wr_c  = wr_c && (req.addr == REG_FILTER);
    tripcnt_wr_c = wr_c && (req.addr == REG_TRIPCNT);
    ack_d        = acc_c;
  end

  // Software-owned configuration registers.
  always_comb begin
    ctrl_d       = ctrl_q;
    timeout_d    = timeout_q;
    mask_d       = mask_q;
    filter_d     = filter_q;
    estop_meta_d = estop_n;
    estop_sync_d = estop_meta_q;
    if (ctrl_wr_c)    ctrl_d    = CTRL_W'(req.data);
    if (timeout_wr_c) timeout_d = WDT_W'(req.data);
    if (mask_wr_c)    mask_d    = N_FAULT'(req.data);
    if (filter_wr_c)  filter_d  = FILT_W'(req.data);
  end

  // Watchdog: a reload beats expiry in the same cycle.
  always_comb begin
    wdt_en_c   = ctrl_q[CTRL_WDT_EN];
    wdt_load_c = kick_wr_c
               || (ctrl_wr_c && !ctrl_q[CTRL_WDT_EN] && req.data[CTRL_WDT_EN])
               || (timeout_wr_c && ctrl_q[CTRL_WDT_EN]);
    wdt_set_c  = wdt_en_c && (wdt_cnt_q == '0) && !wdt_load_c;
    wdt_cnt_d  = wdt_cnt_q;
    if (wdt_load_c) begin
      wdt_cnt_d = timeout_d;
    end else if (wdt_en_c && (wdt_cnt_q != '0)) begin
      wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
    end
  end

  // Sticky status: a new set overrides a simultaneous clear.
  always_comb begin
    estop_live_c = !estop_sync_q;
    set_c        = {wdt_set_c, estop_live_c, chan_qual};
    trip_src_c   = {wdt_set_c, estop_live_c, chan_qual & mask_q};
    w1c_c        = status_wr_c ? N_SRC'(req.data) : '0;
    status_d     = (status_q & ~w1c_c) | set_c;
    first_d      = first_q;
    if (status_d == '0) begin
      first_d = '0;
    end else if (!first_q.valid && (trip_src_c != '0)) begin
      first_d.valid = 1'b1;
      first_d.idx   = lowest_idx(MAX_SRC'(trip_src_c));
    end
  end

  always_comb begin
    latched_c = ((status_q[N_FAULT-1:0] & mask_q) != '0)
              || status_q[IDX_ESTOP] || status_q[IDX_WDT];
    trip_c    = latched_c || ctrl_q[CTRL_FORCE_DIS] || estop_live_c;
  end

  assign pwm_disable = trip_c;
  assign irq         = latched_c;

  // Trip counter counts kill-line rising edges; software clear wins.
  always_comb begin
    trip_prev_d = trip_c;
    tripcnt_d   = tripcnt_q;
    if (tripcnt_wr_c) begin
      tripcnt_d = '0;
    end else if (trip_c && !trip_prev_q && (tripcnt_q != '1)) begin
      tripcnt_d = tripcnt_q + TRIPCNT_W'(1);
    end
  end

  // Read mux; data is registered alongside the ack.
  always_comb begin
    raw_c                         = {wdt_en_c && (wdt_cnt_q == '0), estop_live_c, chan_level};
    first_word_c                  = '0;
    first_word_c[FIRST_VALID_BIT] = first_q.valid;
    first_word_c[FIRST_IDX_W-1:0] = first_q.idx;
    dat_d                         = '0;
    if (rd_c) begin
      case (req.addr)
        REG_CTRL:    dat_d = DATA_W'(ctrl_q);
        REG_TIMEOUT: dat_d = DATA_W'(timeout_q);
        REG_STATUS:  dat_d = DATA_W'(status_q);
        REG_MASK:    dat_d = DATA_W'(mask_q);
        REG_FILTER:  dat_d = DATA_W'(filter_q);
        REG_FIRST:   dat_d = first_word_c;
        REG_RAW:     dat_d = DATA_W'(raw_c);
        REG_TRIPCNT: dat_d = DATA_W'(tripcnt_q);
        default:     dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      ctrl_q       <= '0;
      timeout_q    <= '1;
      mask_q       <= '1;
      filter_q     <= '0;
      status_q     <= '0;
      first_q      <= '0;
      wdt_cnt_q    <= '0;
      tripcnt_q    <= '0;
      trip_prev_q  <= 1'b0;
      estop_meta_q <= 1'b1;
      estop_sync_q <= 1'b1;
    end else begin
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      ctrl_q       <= ctrl_d;
      timeout_q    <= timeout_d;
      mask_q       <= mask_d;
      filter_q     <= filter_d;
      status_q     <= status_d;
      first_q      <= first_d;
      wdt_cnt_q    <= wdt_cnt_d;
      tripcnt_q    <= tripcnt_d;
      trip_prev_q  <= trip_prev_d;
      estop_meta_q <= estop_meta_d;
      estop_sync_q <= estop_sync_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_fault_manager.sv
// Self-checking bench for fault_manager: randomised scenarios checked against
// expectations derived from pulse lengths, source priorities and edge counts.
module tb_fault_manager;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   wb_addr;
  logic [31:0]  wb_dat_i;
  logic [31:0]  wb_dat_o;
  logic         wb_we;
  logic [3:0]   wb_sel;
  logic         wb_stb;
  logic         wb_ack;
  logic [N-1:0] fault_in;
  logic         estop_n;
  logic         pwm_disable;
  logic         irq;

  int checks = 0;
  int errors = 0;
  int exp_trips = 0;

  fault_manager #(.N_FAULT(N), .FILT_W(8), .WDT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb),
    .wb_ack(wb_ack), .fault_in(fault_in), .estop_n(estop_n),
    .pwm_disable(pwm_disable), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb_cycle(input logic [7:0] a, input logic [31:0] d, input logic we,
                          input logic [3:0] sel, output logic [31:0] rdata);
    int n;
    wb_addr = a; wb_dat_i = d; wb_we = we; wb_sel = sel; wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
    checks++;
    if (wb_ack !== 1'b1) begin
      errors++;
      $display("FAIL wb_ack_timeout addr=%h got=%b want=1", a, wb_ack);
    end
    rdata = wb_dat_o;
    wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(a, d, 1'b1, 4'hF, dummy);
  endtask

  task automatic wb_rd(input logic [7:0] a, output logic [31:0] d);
    wb_cycle(a, 32'h0, 1'b0, 4'hF, d);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [31:0] exp_regs [9];
    logic [7:0]  addrs [9];
    addrs    = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20};
    exp_regs = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0};
    checks++;
    if ({wb_ack, pwm_disable, irq} !== 3'b000 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b/%h want=000/0", wb_ack, pwm_disable, irq, wb_dat_o);
    end
    for (int i = 0; i < 9; i++) begin
      wb_rd(addrs[i], rd);
      checks++;
      if (rd !== exp_regs[i]) begin
        errors++;
        $display("FAIL reset_reg_%h got=%h want=%h", addrs[i], rd, exp_regs[i]);
      end
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd;
    fault_in[2] = 1'b1;
    tick(1);
    fault_in[2] = 1'b0;
    tick(1);
    checks++;
    if (pwm_disable !== 1'b0) begin
      errors++; $display("FAIL latency_early got=%b want=0", pwm_disable);
    end
    tick(1);
    checks++;
    if ({pwm_disable, irq} !== 2'b11) begin
      errors++; $display("FAIL latency_edge3 got=%b want=11", {pwm_disable, irq});
    end
    exp_trips++;
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL latency_status got=%h want=04", rd); end
    wb_rd(8'h18, rd);
    checks++;
    if (rd !== 32'h82) begin errors++; $display("FAIL latency_first got=%h want=82", rd); end
    wb_rd(8'h20, rd);
    checks++;
    if (rd !== 32'(exp_trips)) begin
      errors++; $display("FAIL latency_tripcnt got=%h want=%h", rd, exp_trips);
    end
    wb_wr(8'h0C, 32'h3F);
  endtask

  // A pulse of L synchronised cycles qualifies iff L exceeds the threshold F.
  task automatic test_filter;
    logic [31:0] rd;
    int ch, f, len;
    bit latched;
    for (int it = 0; it < 8; it++) begin
      if (it == 0)      begin ch = 0; f = 5; len = 5; end
      else if (it == 1) begin ch = 0; f = 5; len = 7; end
      else begin
        ch  = int'($urandom_range(N - 1));
        f   = int'($urandom_range(6));
        len = int'($urandom_range(f + 3, 1));
      end
      latched = (len >= f + 1);
      wb_wr(8'h14, 32'(f));
      fault_in[ch] = 1'b1;
      tick(len);
      fault_in[ch] = 1'b0;
      tick(4);
      checks++;
      if ({pwm_disable, irq} !== {latched, latched}) begin
        errors++;
        $display("FAIL filter_out ch=%0d F=%0d L=%0d got=%b want=%b", ch, f, len,
                 {pwm_disable, irq}, {latched, latched});
      end
      wb_rd(8'h0C, rd);
      checks++;
      if (rd !== (latched ? (32'h1 << ch) : 32'h0)) begin
        errors++;
        $display("FAIL filter_status ch=%0d F=%0d L=%0d got=%h want=%0d", ch, f, len, rd, latched);
      end
      wb_rd(8'h18, rd);
      checks++;
      if (rd !== (latched ? (32'h80 | 32'(ch)) : 32'h0)) begin
        errors++; $display("FAIL filter_first ch=%0d got=%h", ch, rd);
      end
      if (latched) exp_trips++;
      wb_wr(8'h0C, 32'h3F);
    end
    wb_wr(8'h14, 32'h0);
  endtask

  task automatic test_mask;
    logic [31:0] rd;
    int ch;
    ch = int'($urandom_range(N - 1));
    wb_wr(8'h10, 32'hF & ~(32'h1 << ch));
    fault_in[ch] = 1'b1;
    tick(1);
    fault_in[ch] = 1'b0;
    tick(4);
    checks++;
    if ({pwm_disable, irq} !== 2'b00) begin
      errors++; $display("FAIL mask_quiet got=%b want=00", {pwm_disable, irq});
    end
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== (32'h1 << ch)) begin errors++; $display("FAIL mask_status got=%h", rd); end
    wb_rd(8'h18, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mask_first got=%h want=0", rd); end
    wb_wr(8'h10, 32'hF);
    checks++;
    if ({pwm_disable, irq} !== 2'b11) begin
      errors++; $display("FAIL mask_unmask got=%b want=11", {pwm_disable, irq});
    end
    exp_trips++;
    wb_wr(8'h0C, 32'h1 << ch);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL mask_clear got=%b want=0", pwm_disable); end
  endtask

  task automatic test_first;
    logic [31:0] rd;
    int a, b;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin a = 1; b = 3; end
      else begin
        a = int'($urandom_range(N - 2));
        b = int'($urandom_range(N - 1, a + 1));
      end
      fault_in[a] = 1'b1; fault_in[b] = 1'b1;
      tick(1);
      fault_in = '0;
      tick(4);
      exp_trips++;
      wb_rd(8'h18, rd);
      checks++;
      if (rd !== (32'h80 | 32'(a))) begin
        errors++; $display("FAIL first_simul a=%0d b=%0d got=%h", a, b, rd);
      end
      wb_wr(8'h0C, 32'h1 << a);
      wb_rd(8'h18, rd);
      checks++;
      if (rd !== (32'h80 | 32'(a))) begin errors++; $display("FAIL first_keep got=%h", rd); end
      wb_wr(8'h0C, 32'h1 << b);
      wb_rd(8'h0C, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL first_status_clr got=%h want=0", rd); end
      wb_rd(8'h18, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL first_clr got=%h want=0", rd); end
    end
  endtask

  task automatic test_w1c_vs_set;
    logic [31:0] rd;
    int ch;
    ch = int'($urandom_range(N - 1));
    fault_in[ch] = 1'b1;
    tick(4);
    exp_trips++;
    wb_rd(8'h1C, rd);
    checks++;
    if (rd !== (32'h1 << ch)) begin errors++; $display("FAIL raw_live got=%h", rd); end
    wb_wr(8'h0C, 32'h1 << ch);
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== (32'h1 << ch)) begin errors++; $display("FAIL w1c_set_wins got=%h", rd); end
    fault_in[ch] = 1'b0;
    tick(4);
    wb_wr(8'h0C, 32'h1 << ch);
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h want=0", rd); end
  endtask

  task automatic test_force_and_bus;
    logic [31:0] rd;
    wb_wr(8'h00, 32'h2);
    checks++;
    if ({pwm_disable, irq} !== 2'b10) begin
      errors++; $display("FAIL force_dis got=%b want=10", {pwm_disable, irq});
    end
    exp_trips++;
    wb_wr(8'h00, 32'h0);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL force_off got=%b", pwm_disable); end
    wb_cycle(8'h10, 32'h3, 1'b1, 4'h3, rd);
    wb_rd(8'h10, rd);
    checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL partial_write got=%h want=f", rd); end
    wb_wr(8'h40, 32'hFFFF_FFFF);
    wb_rd(8'h40, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped got=%h want=0", rd); end
    wb_rd(8'h20, rd);
    checks++;
    if (rd !== 32'(exp_trips)) begin errors++; $display("FAIL tripcnt got=%h want=%h", rd, exp_trips); end
  endtask

  task automatic test_wdt;
    logic [31:0] rd;
    int t;
    t = int'($urandom_range(60, 8));
    // Enable loads T at the ack edge; expiry latches T edges after the task returns.
    wb_wr(8'h04, 32'(t));
    wb_wr(8'h00, 32'h1);
    tick(t - 1);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL wdt_early T=%0d got=%b", t, pwm_disable); end
    tick(1);
    checks++;
    if ({pwm_disable, irq} !== 2'b11) begin
      errors++; $display("FAIL wdt_expire T=%0d got=%b want=11", t, {pwm_disable, irq});
    end
    exp_trips++;
    wb_rd(8'h18, rd);
    checks++;
    if (rd !== 32'h85) begin errors++; $display("FAIL wdt_first got=%h want=85", rd); end
    wb_wr(8'h00, 32'h0);
    wb_wr(8'h0C, 32'h3F);
    // Kick lands on the cycle the counter sits at zero.
    wb_wr(8'h00, 32'h1);
    tick(t - 1);
    wb_wr(8'h08, 32'h0);
    wb_wr(8'h00, 32'h0);
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wdt_kick_wins got=%h want=0", rd); end
    wb_wr(8'h04, 32'h1000);
    wb_wr(8'h00, 32'h1);
    tick(5000);
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h20) begin errors++; $display("FAIL wdt_4k got=%h want=20", rd); end
    exp_trips++;
    wb_wr(8'h00, 32'h0);
    wb_wr(8'h0C, 32'h3F);
    wb_wr(8'h04, 32'h10000);
    wb_wr(8'h00, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick(250);
      wb_wr(8'h08, 32'h1);
    end
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wdt_kicked got=%h want=0", rd); end
    wb_wr(8'h00, 32'h0);
  endtask

  task automatic test_estop;
    logic [31:0] rd;
    estop_n = 1'b0;
    tick(1);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL estop_edge1 got=%b want=0", pwm_disable); end
    tick(1);
    checks++;
    if (pwm_disable !== 1'b1) begin errors++; $display("FAIL estop_edge2 got=%b want=1", pwm_disable); end
    exp_trips++;
    tick(2);
    wb_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL estop_status got=%h want=10", rd); end
    wb_rd(8'h18, rd);
    checks++;
    if (rd !== 32'h84) begin errors++; $display("FAIL estop_first got=%h want=84", rd); end
    estop_n = 1'b1;
    tick(4);
    checks++;
    if ({pwm_disable, irq} !== 2'b11) begin
      errors++; $display("FAIL estop_latched got=%b want=11", {pwm_disable, irq});
    end
    wb_wr(8'h0C, 32'h10);
    checks++;
    if ({pwm_disable, irq} !== 2'b00) begin
      errors++; $display("FAIL estop_clear got=%b want=00", {pwm_disable, irq});
    end
    wb_rd(8'h20, rd);
    checks++;
    if (rd !== 32'(exp_trips)) begin errors++; $display("FAIL estop_tripcnt got=%h want=%h", rd, exp_trips); end
    wb_wr(8'h20, 32'h0);
    exp_trips = 0;
    wb_rd(8'h20, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL tripcnt_clear got=%h want=0", rd); end
  endtask

  task automatic test_reset_mid;
    int ch;
    ch = int'($urandom_range(N - 1));
    wb_wr(8'h14, 32'h3);
    wb_wr(8'h04, 32'h1234);
    wb_wr(8'h00, 32'h2);
    wb_wr(8'h14, 32'h0);
    fault_in[ch] = 1'b1;
    tick(1);
    fault_in[ch] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({pwm_disable, irq} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_out got=%b want=00", {pwm_disable, irq});
    end
    tick(1);
    rst_n = 1'b1;
    test_reset();
    rst_n = 1'b0;
    estop_n = 1'b0;
    tick(3);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL reset_estop_hold got=%b want=0", pwm_disable); end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL reset_estop_e1 got=%b want=0", pwm_disable); end
    tick(1);
    checks++;
    if (pwm_disable !== 1'b1) begin errors++; $display("FAIL reset_estop_e2 got=%b want=1", pwm_disable); end
    estop_n = 1'b1;
    tick(4);
    wb_wr(8'h0C, 32'h10);
    checks++;
    if (pwm_disable !== 1'b0) begin errors++; $display("FAIL reset_estop_clr got=%b want=0", pwm_disable); end
  endtask

  initial begin
    rst_n = 1'b0; wb_addr = '0; wb_dat_i = '0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_stb = 1'b0; fault_in = '0; estop_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_filter();
    test_mask();
    test_first();
    test_w1c_vs_set();
    test_force_and_bus();
    test_wdt();
    test_estop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
